// File: rtl/aes_inv_key_schedule.sv
`default_nettype none
// ============================================================================
// Module   : aes_inv_key_schedule
// Brief    : Iterative AES-128 inverse key schedule, emits round keys 10..0
// Revision : 1.0  initial release
// ============================================================================
module aes_inv_key_schedule (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [127:0] last_key,
    output logic [127:0] round_key,
    output logic [3:0]   round_idx,
    output logic         key_valid,
    input  logic         key_ready,
    output logic         busy,
    output logic         done
);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_RUN  = 2'd1;
    localparam logic [1:0] c_DONE = 2'd2;

    // Forward AES S-box, entry 0 in the top byte.
    localparam logic [2047:0] c_SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    logic [1:0]   r_state;
    logic [31:0]  w_p0, w_p1, w_p2, w_p3;
    logic [31:0]  w_rot;
    logic [31:0]  w_sub;
    logic [7:0]   w_rcon;
    logic [127:0] w_prev_key;

    assign w_p3  = round_key[31:0]  ^ round_key[63:32];
    assign w_p2  = round_key[63:32] ^ round_key[95:64];
    assign w_p1  = round_key[95:64] ^ round_key[127:96];
    assign w_rot = {w_p3[23:0], w_p3[31:24]};

    for (genvar g = 0; g < 4; g++) begin : g_sbox
        logic [10:0] w_base;
        assign w_base           = 11'd2047 - {w_rot[8*g +: 8], 3'b000};
        assign w_sub[8*g +: 8]  = c_SBOX[w_base -: 8];
    end

    // Rcon is indexed by the round being left, not the one being entered.
    always_comb begin
        w_rcon = 8'h00;
        case (round_idx)
            4'd1:    w_rcon = 8'h01;
            4'd2:    w_rcon = 8'h02;
            4'd3:    w_rcon = 8'h04;
            4'd4:    w_rcon = 8'h08;
            4'd5:    w_rcon = 8'h10;
            4'd6:    w_rcon = 8'h20;
            4'd7:    w_rcon = 8'h40;
            4'd8:    w_rcon = 8'h80;
            4'd9:    w_rcon = 8'h1b;
            4'd10:   w_rcon = 8'h36;
            default: w_rcon = 8'h00;
        endcase
    end

    assign w_p0       = round_key[127:96] ^ w_sub ^ {w_rcon, 24'h000000};
    assign w_prev_key = {w_p0, w_p1, w_p2, w_p3};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= c_IDLE;
            round_key <= 128'h0;
            round_idx <= 4'd0;
            key_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        round_key <= last_key;
                        round_idx <= 4'd10;
                        key_valid <= 1'b1;
                        busy      <= 1'b1;
                        r_state   <= c_RUN;
                    end
                end
                c_RUN: begin
                    if (key_ready) begin
                        if (round_idx != 4'd0) begin
                            round_key <= w_prev_key;
                            round_idx <= round_idx - 4'd1;
                        end else begin
                            key_valid <= 1'b0;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                            r_state   <= c_DONE;
                        end
                    end
                end
                c_DONE: begin
                    done    <= 1'b0;
                    r_state <= c_IDLE;
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire
